kmeans_sequencer: RTL and testbench

Iteration controller for the k-means clustering datapath. It streams points from an external point memory into the accumulator/classifier, then commits the averaged centroids, and repeats until the centroid set converges or an iteration limit is hit. It owns every control strobe of the accumulator (clear, accumulate, swap) and the load strobe of the centroid register bank, and reports status to the host.

---
 rtl/kmeans_sequencer.sv | 157 +++++++++++++++
 tb/tb_kmeans_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/kmeans_sequencer.sv
// Iteration controller for the k-means datapath: streams points into the accumulator,
// commits and loads centroids, and repeats until convergence or the iteration limit.
module kmeans_sequencer #(
   parameter int n      = 8,
   parameter int d      = 2,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   num_points,
   input  logic [7:0]        max_iter,
   input  logic              converged,
   output logic [ADDR_W-1:0] pt_addr,
   output logic              pt_rd_en,
   output logic              acc_clr,
   output logic              acc,
   output logic              swap,
   output logic              load_centroids,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              conv_flag,
   output logic [7:0]        iter_count
);

   if (ADDR_W < 1 || n < 0 || d < 1) begin : g_bad_params
      $error("kmeans_sequencer: illegal parameter set");
   end

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_FETCH = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_SWAP  = 3'd4;
   localparam logic [2:0] S_LOAD  = 3'd5;
   localparam logic [2:0] S_CHECK = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   localparam logic [ADDR_W:0] ADDR_INC = {{ADDR_W{1'b0}}, 1'b1};

   logic [2:0]      state_q, state_d;
   logic [ADDR_W:0] addr_q, addr_d;
   logic [ADDR_W:0] n_q, n_d;
   logic [7:0]      m_q, m_d;
   logic [7:0]      iter_q, iter_d;
   logic            conv_q, conv_d;
   logic            err_q, err_d;
   logic            acc_q, acc_d;

   always_comb begin
      // NOTE: every next-state signal takes its hold value first so no path can infer a latch.
      state_d = state_q;
      addr_d  = addr_q;
      n_d     = n_q;
      m_d     = m_q;
      iter_d  = iter_q;
      conv_d  = conv_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d    = num_points;
               m_d    = max_iter;
               iter_d = 8'd0;
               conv_d = 1'b0;
               if (num_points == '0 || max_iter == 8'd0) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = S_CLEAR;
               end
            end
         end
         S_CLEAR: begin
            addr_d  = '0;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            // The counter is one bit wider than pt_addr, so N == 2**ADDR_W terminates cleanly.
            if (addr_q + ADDR_INC == n_q) begin
               state_d = S_DRAIN;
            end else begin
               addr_d = addr_q + ADDR_INC;
            end
         end
         S_DRAIN: state_d = S_SWAP;
         S_SWAP:  state_d = S_LOAD;
         S_LOAD:  state_d = S_CHECK;
         S_CHECK: begin
            iter_d = iter_q + 8'd1;
            if (converged) begin
               conv_d  = 1'b1;
               state_d = S_DONE;
            end else if (iter_q + 8'd1 == m_q) begin
               state_d = S_DONE;
            end else begin
               state_d = S_CLEAR;
            end
         end
         S_DONE: begin
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides every transition and freezes the reported status.
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         iter_d  = iter_q;
         conv_d  = conv_q;
         err_d   = 1'b0;
      end

      acc_d = (state_q == S_FETCH) && !abort;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         n_q     <= '0;
         m_q     <= '0;
         iter_q  <= '0;
         conv_q  <= 1'b0;
         err_q   <= 1'b0;
         acc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         n_q     <= n_d;
         m_q     <= m_d;
         iter_q  <= iter_d;
         conv_q  <= conv_d;
         err_q   <= err_d;
         acc_q   <= acc_d;
      end
   end

   assign pt_rd_en       = (state_q == S_FETCH);
   assign pt_addr        = pt_rd_en ? addr_q[ADDR_W-1:0] : '0;
   assign acc_clr        = (state_q == S_CLEAR);
   assign acc            = acc_q;
   assign swap           = (state_q == S_SWAP);
   assign load_centroids = (state_q == S_LOAD);
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign err            = (state_q == S_DONE) && err_q;
   assign conv_flag      = conv_q;
   assign iter_count     = iter_q;

endmodule

// File: tb/tb_kmeans_sequencer.sv
// Directed bench for kmeans_sequencer: per-run cycle-accurate strobe counts, address
// sequence, acc alignment and status against hand-computed expectations.
module tb_kmeans_sequencer;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic [ADDR_W:0]   num_points;
   logic [7:0]        max_iter;
   logic              converged;
   logic [ADDR_W-1:0] pt_addr;
   logic              pt_rd_en;
   logic              acc_clr;
   logic              acc;
   logic              swap;
   logic              load_centroids;
   logic              busy;
   logic              done;
   logic              err;
   logic              conv_flag;
   logic [7:0]        iter_count;

   int n_checks = 0;
   int n_fail   = 0;

   kmeans_sequencer #(.n(8), .d(2), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .num_points     (num_points),
      .max_iter       (max_iter),
      .converged      (converged),
      .pt_addr        (pt_addr),
      .pt_rd_en       (pt_rd_en),
      .acc_clr        (acc_clr),
      .acc            (acc),
      .swap           (swap),
      .load_centroids (load_centroids),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .conv_flag      (conv_flag),
      .iter_count     (iter_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {37'd0, pt_addr, pt_rd_en, acc_clr, acc, swap, load_centroids,
              busy, done, err, conv_flag, iter_count};
   endfunction

   // Cycle t is the clock period that ends at edge E0+t, E0 being the accepting edge.
   task automatic run_job(input string name, input int n_pts, input int m_it,
                          input int conv_after, input int abort_at, input int repulse_at,
                          input int budget, input int e_done, input int e_err,
                          input int e_clr, input int e_rd, input int e_acc, input int e_swap,
                          input int e_load, input int e_iter, input int e_conv,
                          input int e_last_busy);
      int done_cyc = 0, done_cnt = 0, err_cnt = 0, clr_cnt = 0, rd_cnt = 0, acc_cnt = 0;
      int swap_cnt = 0, load_cnt = 0, addr_bad = 0, lag_bad = 0, last_busy = 0;
      logic prev_rd = 1'b0;
      logic exp_acc;
      @(negedge clk);
      num_points = n_pts[ADDR_W:0];
      max_iter   = m_it[7:0];
      converged  = 1'b0;
      abort      = 1'b0;
      start      = 1'b1;
      for (int t = 1; t <= budget; t++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         if (pt_rd_en) begin
            if (n_pts == 0 || int'(pt_addr) != (rd_cnt % n_pts)) addr_bad++;
            rd_cnt++;
         end
         exp_acc = prev_rd && (t != abort_at + 1);
         if (acc !== exp_acc) lag_bad++;
         prev_rd = pt_rd_en;
         if (acc)            acc_cnt++;
         if (acc_clr)        clr_cnt++;
         if (swap)           swap_cnt++;
         if (load_centroids) load_cnt++;
         if (err)            err_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = t;
         end
         if (busy) last_busy = t;
         converged = (load_cnt >= conv_after);
         if (t == abort_at)   abort = 1'b1;
         if (t == repulse_at) start = 1'b1;
      end
      check({name, ".done_cycle"}, 64'(done_cyc), 64'(e_done));
      check({name, ".done_count"}, 64'(done_cnt), 64'(e_done != 0 ? 1 : 0));
      check({name, ".err_count"},  64'(err_cnt),  64'(e_err));
      check({name, ".clr_count"},  64'(clr_cnt),  64'(e_clr));
      check({name, ".rd_count"},   64'(rd_cnt),   64'(e_rd));
      check({name, ".acc_count"},  64'(acc_cnt),  64'(e_acc));
      check({name, ".swap_count"}, 64'(swap_cnt), 64'(e_swap));
      check({name, ".load_count"}, 64'(load_cnt), 64'(e_load));
      check({name, ".addr_bad"},   64'(addr_bad), 64'd0);
      check({name, ".acc_lag_bad"}, 64'(lag_bad), 64'd0);
      check({name, ".iter_count"}, 64'(iter_count), 64'(e_iter));
      check({name, ".conv_flag"},  64'(conv_flag),  64'(e_conv));
      check({name, ".last_busy"},  64'(last_busy),  64'(e_last_busy));
   endtask

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      num_points = '0;
      max_iter   = '0;
      converged  = 1'b0;
      repeat (3) @(negedge clk);
      check("por.outputs", all_outs(), 64'd0);
      rst = 1'b1;

      //        name     N     M   conv  abrt rep  budget done err clr rd   acc  swp ld  it cv busy
      run_job("conv2", 4,    10,  2,    0,   0,   24,    19,  0,  2,  8,   8,   2,  2,  2, 1, 19);

      // Reset mid-FETCH of a fresh run.
      @(negedge clk);
      num_points = 11'd8;
      max_iter   = 8'd2;
      start      = 1'b1;
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("rst.pre_busy", 64'(busy), 64'd1);
      rst = 1'b0;
      @(negedge clk);
      check("rst.outputs_1", all_outs(), 64'd0);
      repeat (2) @(negedge clk);
      check("rst.outputs_3", all_outs(), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rst.idle_after", all_outs(), 64'd0);

      run_job("limit3", 4,    3,   1000, 0,   10,  32,    28,  0,  3,  12,  12,  3,  3,  3, 0, 28);
      run_job("n_zero", 0,    5,   1000, 0,   0,   5,     1,   1,  0,  0,   0,   0,  0,  0, 0, 1);
      run_job("m_zero", 3,    0,   1000, 0,   0,   5,     1,   1,  0,  0,   0,   0,  0,  0, 0, 1);
      run_job("abort",  8,    5,   1000, 17,  5,   25,    0,   0,  2,  11,  10,  1,  1,  1, 0, 17);
      run_job("full",   1024, 1,   1000, 0,   0,   1034,  1030, 0, 1,  1024, 1024, 1, 1,  1, 0, 1030);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
